// File: rtl/tl_tx_fc_credit_gate.sv
// tl_tx_fc_credit_gate: TX flow-control credit gate for the TL transmit path.
// Tracks far-receiver credit limits (InitFC/UpdateFC) and locally consumed
// credits per type (P, NP, CPL), and grants a pending TLP only when both its
// header and data credits fit inside the advertised window.
// Optional stall timer: define TL_TX_FC_STALL_TIMER_EN.
module tl_tx_fc_credit_gate #(
  parameter int unsigned HDR_FIELD_SIZE  = 8,
  parameter int unsigned DATA_FIELD_SIZE = 12,
  parameter int unsigned STALL_LIMIT     = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_dl_up,
  input  logic                       i_fc_valid,
  input  logic                       i_fc_init,
  input  logic [1:0]                 i_fc_typ,
  input  logic [HDR_FIELD_SIZE-1:0]  i_fc_hdr,
  input  logic [DATA_FIELD_SIZE-1:0] i_fc_data,
  input  logic                       i_tlp_req,
  input  logic [1:0]                 i_tlp_typ,
  input  logic [HDR_FIELD_SIZE-1:0]  i_tlp_hdr_credits,
  input  logic [DATA_FIELD_SIZE-1:0] i_tlp_data_credits,
  output logic                       o_tlp_grant,
  output logic                       o_tlp_blocked,
  output logic                       o_fc_ready,
  output logic                       o_fc_stall
);

  localparam int unsigned HW      = HDR_FIELD_SIZE;
  localparam int unsigned DW      = DATA_FIELD_SIZE;
  localparam int unsigned NUM_TYP = 4;
  localparam logic [HW-1:0] HDR_HALF  = HW'(1) << (HW - 1);
  localparam logic [DW-1:0] DATA_HALF = DW'(1) << (DW - 1);

  typedef enum logic {FC_INIT, FC_ACTIVE} fc_state_t;

  fc_state_t state, state_nxt;

  // Index 3 (reserved type) is never written and never passes the check.
  logic [HW-1:0]      hdr_lim   [NUM_TYP];
  logic [HW-1:0]      hdr_cons  [NUM_TYP];
  logic [DW-1:0]      data_lim  [NUM_TYP];
  logic [DW-1:0]      data_cons [NUM_TYP];
  logic [NUM_TYP-1:0] hdr_inf;
  logic [NUM_TYP-1:0] data_inf;
  logic [2:0]         init_seen;

  logic [HW-1:0] hdr_room;
  logic [DW-1:0] data_room;
  logic          hdr_pass, data_pass, tlp_pass;
  logic          eval, grant_nxt, blocked_nxt;
  logic          fc_init_wr, fc_upd_wr;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FC_INIT;
    else       state <= state_nxt;
  end

  // Next state: link-down always re-initialises; leave INIT once all types seen.
  always_comb begin
    state_nxt = state;
    if (!i_dl_up) begin
      state_nxt = FC_INIT;
    end else begin
      case (state)
        FC_INIT:   if (&init_seen) state_nxt = FC_ACTIVE;
        FC_ACTIVE: state_nxt = FC_ACTIVE;
        default:   state_nxt = FC_INIT;
      endcase
    end
  end

  // Gating check (modulo window compare) and grant/blocked decision.
  always_comb begin
    hdr_room    = hdr_lim[i_tlp_typ] - (hdr_cons[i_tlp_typ] + i_tlp_hdr_credits);
    data_room   = data_lim[i_tlp_typ] - (data_cons[i_tlp_typ] + i_tlp_data_credits);
    hdr_pass    = hdr_inf[i_tlp_typ] | (hdr_room <= HDR_HALF);
    data_pass   = data_inf[i_tlp_typ] | (data_room <= DATA_HALF);
    tlp_pass    = (i_tlp_typ != 2'b11) & hdr_pass & data_pass;
    // The cycle showing a grant is the mandatory bubble: the request is stale.
    eval        = (state == FC_ACTIVE) & i_dl_up & i_tlp_req & ~o_tlp_grant;
    grant_nxt   = eval & tlp_pass;
    blocked_nxt = eval & ~tlp_pass;
    fc_init_wr  = i_fc_valid & (i_fc_typ != 2'b11) & i_fc_init & (state == FC_INIT);
    fc_upd_wr   = i_fc_valid & (i_fc_typ != 2'b11) & ~i_fc_init & (state == FC_ACTIVE);
  end

  // Credit limits, consumed counters, infinite and init-seen flags.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_dl_up) begin
      for (int i = 0; i < NUM_TYP; i++) begin
        hdr_lim[i]   <= '0;
        hdr_cons[i]  <= '0;
        data_lim[i]  <= '0;
        data_cons[i] <= '0;
      end
      hdr_inf   <= '0;
      data_inf  <= '0;
      init_seen <= '0;
    end else begin
      if (fc_init_wr) begin
        hdr_lim[i_fc_typ]   <= i_fc_hdr;
        data_lim[i_fc_typ]  <= i_fc_data;
        hdr_cons[i_fc_typ]  <= '0;
        data_cons[i_fc_typ] <= '0;
        hdr_inf[i_fc_typ]   <= (i_fc_hdr == '0);
        data_inf[i_fc_typ]  <= (i_fc_data == '0);
        init_seen           <= init_seen | (3'b001 << i_fc_typ);
      end
      if (fc_upd_wr) begin
        if (!hdr_inf[i_fc_typ])  hdr_lim[i_fc_typ]  <= i_fc_hdr;
        if (!data_inf[i_fc_typ]) data_lim[i_fc_typ] <= i_fc_data;
      end
      if (grant_nxt) begin
        if (!hdr_inf[i_tlp_typ])
          hdr_cons[i_tlp_typ] <= hdr_cons[i_tlp_typ] + i_tlp_hdr_credits;
        if (!data_inf[i_tlp_typ])
          data_cons[i_tlp_typ] <= data_cons[i_tlp_typ] + i_tlp_data_credits;
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_dl_up) begin
      o_tlp_grant   <= 1'b0;
      o_tlp_blocked <= 1'b0;
      o_fc_ready    <= 1'b0;
    end else begin
      o_tlp_grant   <= grant_nxt;
      o_tlp_blocked <= blocked_nxt;
      o_fc_ready    <= (state_nxt == FC_ACTIVE);
    end
  end

`ifdef TL_TX_FC_STALL_TIMER_EN
  localparam int unsigned SCW = $clog2(STALL_LIMIT + 1);

  logic [SCW-1:0] stall_cnt;

  // Blocked-cycle counter with sticky stall flag (cleared only by INIT).
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_dl_up || (state == FC_INIT)) begin
      stall_cnt  <= '0;
      o_fc_stall <= 1'b0;
    end else begin
      if (o_tlp_grant || !i_tlp_req)
        stall_cnt <= '0;
      else if (o_tlp_blocked && (stall_cnt != SCW'(STALL_LIMIT)))
        stall_cnt <= stall_cnt + SCW'(1);
      if (stall_cnt == SCW'(STALL_LIMIT))
        o_fc_stall <= 1'b1;
    end
  end
`else
  // No timer built; the limit has no effect in this build.
  assign o_fc_stall = 1'b0 && (STALL_LIMIT != 0);
`endif

endmodule

// File: tb/tb_tl_tx_fc_credit_gate.sv
// Testbench for tl_tx_fc_credit_gate: directed scenarios plus random traffic,
// checked against a credit-window reference model.
module tb_tl_tx_fc_credit_gate;

  logic        clk;
  logic        rst, dl_up, fc_valid, fc_init, tlp_req;
  logic [1:0]  fc_typ, tlp_typ;
  logic [7:0]  fc_hdr, tlp_hdr;
  logic [11:0] fc_data, tlp_data;
  logic        grant, blocked, ready, stall;

  int total = 0;
  int bad   = 0;

  // Reference model: credits as plain integers, windows compared mod 2^F.
  int m_hlim [3], m_hcons [3], m_dlim [3], m_dcons [3];
  bit m_hinf [3], m_dinf [3], m_seen [3];
  bit m_active, m_grant, m_blocked;

  tl_tx_fc_credit_gate #(
    .HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12), .STALL_LIMIT(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dl_up(dl_up),
    .i_fc_valid(fc_valid), .i_fc_init(fc_init), .i_fc_typ(fc_typ),
    .i_fc_hdr(fc_hdr), .i_fc_data(fc_data),
    .i_tlp_req(tlp_req), .i_tlp_typ(tlp_typ),
    .i_tlp_hdr_credits(tlp_hdr), .i_tlp_data_credits(tlp_data),
    .o_tlp_grant(grant), .o_tlp_blocked(blocked),
    .o_fc_ready(ready), .o_fc_stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic step();
    int  t, tt;
    bit  hp, dp, pass, ev, ng, nb, nact;
    tt   = int'(tlp_typ);
    pass = 1'b0;
    if (tt != 3) begin
      hp   = m_hinf[tt] || (((m_hlim[tt] - m_hcons[tt] - int'(tlp_hdr)) & 255) <= 128);
      dp   = m_dinf[tt] || (((m_dlim[tt] - m_dcons[tt] - int'(tlp_data)) & 4095) <= 2048);
      pass = hp && dp;
    end
    ev = m_active && dl_up && tlp_req && !m_grant;
    ng = ev && pass;
    nb = ev && !pass;
    if (rst || !dl_up) begin
      for (int i = 0; i < 3; i++) begin
        m_hlim[i] = 0; m_hcons[i] = 0; m_dlim[i] = 0; m_dcons[i] = 0;
        m_hinf[i] = 0; m_dinf[i] = 0; m_seen[i] = 0;
      end
      m_active = 0; ng = 0; nb = 0;
    end else begin
      nact = m_active || (m_seen[0] && m_seen[1] && m_seen[2]);
      t = int'(fc_typ);
      if (fc_valid && t != 3) begin
        if (fc_init && !m_active) begin
          m_hlim[t] = int'(fc_hdr); m_dlim[t] = int'(fc_data);
          m_hcons[t] = 0; m_dcons[t] = 0;
          m_hinf[t] = (fc_hdr == 0); m_dinf[t] = (fc_data == 0);
          m_seen[t] = 1;
        end else if (!fc_init && m_active) begin
          if (!m_hinf[t]) m_hlim[t] = int'(fc_hdr);
          if (!m_dinf[t]) m_dlim[t] = int'(fc_data);
        end
      end
      if (ng) begin
        if (!m_hinf[tt]) m_hcons[tt] = (m_hcons[tt] + int'(tlp_hdr)) & 255;
        if (!m_dinf[tt]) m_dcons[tt] = (m_dcons[tt] + int'(tlp_data)) & 4095;
      end
      m_active = nact;
    end
    m_grant   = ng;
    m_blocked = nb;
    @(posedge clk);
    #1;
  endtask

  // Present an FC DLLP for the next step.
  task automatic set_fc(input bit init, input int typ, input int h, input int d);
    fc_valid = 1'b1;
    fc_init  = init;
    fc_typ   = 2'(typ);
    fc_hdr   = 8'(h);
    fc_data  = 12'(d);
  endtask

  // InitFC for P (given values), NP and CPL (infinite), then one settle cycle.
  task automatic init_all(input int ph, input int pd);
    set_fc(1, 0, ph, pd); step();
    set_fc(1, 1, 0, 0);   step();
    set_fc(1, 2, 0, 0);   step();
    fc_valid = 1'b0;      step();
  endtask

  task automatic test_reset();
    rst = 1'b1; dl_up = 1'b1; fc_valid = 0; fc_init = 0; fc_typ = 0;
    fc_hdr = 0; fc_data = 0; tlp_req = 0; tlp_typ = 0; tlp_hdr = 0; tlp_data = 0;
    m_grant = 0; m_active = 0;
    step(); step();
    rst = 1'b0;
    step();
    total++; if (grant !== 1'b0)   begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
    total++; if (blocked !== 1'b0) begin bad++; $display("FAIL reset_blocked: got %b want 0", blocked); end
    total++; if (ready !== 1'b0)   begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (stall !== 1'b0)   begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_init();
    set_fc(1, 0, 4, 16); step();
    set_fc(1, 1, 0, 0);  step();
    set_fc(1, 2, 0, 0);  step();
    fc_valid = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_ready_early: got %b want 0", ready); end
    step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL init_ready: got %b want 1", ready); end
    for (int t = 1; t <= 2; t++) begin
      tlp_req = 1; tlp_typ = 2'(t);
      tlp_hdr = 8'($urandom_range(0, 255)); tlp_data = 12'($urandom_range(0, 4095));
      step();
      total++; if (grant !== 1'b1) begin bad++; $display("FAIL init_inf_grant typ=%0d: got %b want 1", t, grant); end
      tlp_req = 0; step();
    end
  endtask

  task automatic test_p_grants();
    for (int k = 0; k < 4; k++) begin
      tlp_req = 1; tlp_typ = 0; tlp_hdr = 1; tlp_data = 4;
      step();
      total++; if (grant !== 1'b1) begin bad++; $display("FAIL p_grant%0d: got %b want 1", k, grant); end
      tlp_req = 0; step();
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL p_bubble%0d: got %b want 0", k, grant); end
    end
    tlp_req = 1; step();
    total++; if (blocked !== 1'b1) begin bad++; $display("FAIL p_fifth_blocked: got %b want 1", blocked); end
    total++; if (grant !== 1'b0)   begin bad++; $display("FAIL p_fifth_grant: got %b want 0", grant); end
  endtask

  task automatic test_update_unblock();
    set_fc(0, 0, 6, 24); step();
    fc_valid = 1'b0;
    total++; if (grant !== 1'b0)   begin bad++; $display("FAIL upd_pre_limit: got %b want 0", grant); end
    total++; if (blocked !== 1'b1) begin bad++; $display("FAIL upd_pre_blocked: got %b want 1", blocked); end
    step();
    total++; if (grant !== 1'b1) begin bad++; $display("FAIL upd_grant: got %b want 1", grant); end
    tlp_req = 0; step();
    tlp_req = 1; step();
    total++; if (grant !== 1'b1) begin bad++; $display("FAIL upd_sixth_grant: got %b want 1", grant); end
    tlp_req = 0; step();
    tlp_req = 1; step();
    total++; if (blocked !== 1'b1) begin bad++; $display("FAIL upd_seventh_blocked: got %b want 1", blocked); end
    tlp_req = 0; step();
  endtask

  task automatic test_dlup_drop();
    int g;
    set_fc(0, 0, 10, 100); step();
    fc_valid = 1'b0;
    tlp_req = 1; tlp_typ = 0; tlp_hdr = 1; tlp_data = 1; dl_up = 0;
    step();
    total++; if (grant !== 1'b0) begin bad++; $display("FAIL drop_grant: got %b want 0", grant); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL drop_ready: got %b want 0", ready); end
    dl_up = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (grant !== 1'b0 || blocked !== 1'b0)
        begin bad++; $display("FAIL drop_init_req: got grant=%b blocked=%b want 0/0", grant, blocked); end
    end
    tlp_req = 0;
    init_all(2, 8);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_reinit_ready: got %b want 1", ready); end
    g = 0;
    for (int k = 0; k < 4; k++) begin
      tlp_req = 1; step();
      if (grant === 1'b1) g++;
      tlp_req = 0; step();
    end
    total++; if (g != 2) begin bad++; $display("FAIL drop_reinit_grants: got %0d want 2", g); end
  endtask

  task automatic test_wrap();
    int g;
    dl_up = 0; step(); dl_up = 1;
    init_all(8, 0);
    for (int k = 0; k < 254; k++) begin
      tlp_req = 1; tlp_typ = 0; tlp_hdr = 1; tlp_data = 12'($urandom_range(0, 50));
      step();
      total++; if (grant !== 1'b1) begin bad++; $display("FAIL wrap_grant%0d: got %b want 1", k, grant); end
      tlp_req = 0;
      set_fc(0, 0, (k + 9) & 255, $urandom_range(0, 4095));
      step();
      fc_valid = 1'b0;
    end
    set_fc(0, 0, 2, 0); step(); fc_valid = 1'b0;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      tlp_req = 1; step();
      total++; if (grant !== m_grant || blocked !== m_blocked)
        begin bad++; $display("FAIL wrap_tail%0d: got %b/%b want %b/%b", k, grant, blocked, m_grant, m_blocked); end
      if (grant === 1'b1) g++;
      tlp_req = 0; step();
    end
    total++; if (g != 4) begin bad++; $display("FAIL wrap_tail_count: got %0d want 4", g); end
  endtask

  task automatic test_stall();
    rst = 1; step(); rst = 0;
    init_all(2, 8);
    for (int k = 0; k < 2; k++) begin
      tlp_req = 1; tlp_typ = 0; tlp_hdr = 1; tlp_data = 1; step();
      tlp_req = 0; step();
    end
    tlp_req = 1;
    for (int k = 1; k <= 40; k++) begin
      step();
`ifdef TL_TX_FC_STALL_TIMER_EN
      if (k == 12) begin
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_early: got %b want 0", stall); end
      end
`else
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_tied: got %b want 0", stall); end
`endif
    end
`ifdef TL_TX_FC_STALL_TIMER_EN
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_set: got %b want 1", stall); end
`endif
    set_fc(0, 0, 10, 80); step(); fc_valid = 1'b0;
    step();
    total++; if (grant !== 1'b1) begin bad++; $display("FAIL stall_grant: got %b want 1", grant); end
    tlp_req = 0; step();
`ifdef TL_TX_FC_STALL_TIMER_EN
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_sticky: got %b want 1", stall); end
`else
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_after: got %b want 0", stall); end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      dl_up    = ($urandom_range(0, 99) != 0);
      fc_valid = ($urandom_range(0, 3) == 0);
      fc_init  = ($urandom_range(0, 2) == 0);
      fc_typ   = 2'($urandom_range(0, 3));
      fc_hdr   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      fc_data  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
      tlp_req  = 1'($urandom_range(0, 1));
      tlp_typ  = 2'($urandom_range(0, 3));
      tlp_hdr  = 8'($urandom_range(0, 3));
      tlp_data = 12'($urandom_range(0, 40));
      step();
      total++; if (grant !== m_grant || blocked !== m_blocked || ready !== m_active)
        begin bad++; $display("FAIL rand%0d: got g=%b b=%b r=%b want g=%b b=%b r=%b",
                              k, grant, blocked, ready, m_grant, m_blocked, m_active); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_p_grants();
    test_update_unblock();
    test_dlup_drop();
    test_wrap();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
